if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the architectural PC and presents `pc_F + 4` to the next-PC selector as its sequential-successor input. It takes the selected next PC back, addresses the 1024-word instruction memory, and registers the fetched word into the IF/ID pipeline register. It implements hazard-unit stalls, an IF/ID clear, and fetch-address error tagging. The next-PC selector is downstream of `add4_F` and upstream of `npc`.

---
 rtl/mips_pkg.sv | 17 +
 rtl/if_id_reg.sv | 37 +++
 rtl/if_stage.sv | 76 +++++++
 tb/tb_if_stage.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory map constants and the IF/ID payload
// that later pipeline registers reuse.
package mips_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam int          IM_WORDS  = 1024;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        addr_err;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and clear both load the all-zero bubble,
// and the register loads new data only when enabled.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clr,
    input  logic   en,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_d;
    if_id_t q_q;

    // clear wins over a stalled (disabled) register
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch-address checker, IF/ID register
// and a count of fetches committed into IF/ID.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
    parameter int          IM_WORDS = mips_pkg::IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        clr_D,
    input  logic [31:0] imem_rdata,
    output logic [9:0]  imem_addr,
    output logic [31:0] pc_F,
    output logic [31:0] add4_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        valid_D,
    output logic        addr_err_D,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

    logic [31:0] pc_d, pc_q;
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic        bad_F;
    if_id_t      if_id_d, if_id_q;

    always_comb begin
        bad_F = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) || (pc_q > PC_LAST);

        if_id_d.instr    = bad_F ? NOP_INSTR : imem_rdata;
        if_id_d.pc       = pc_q;
        if_id_d.pc4      = add4_F;
        if_id_d.valid    = 1'b1;
        if_id_d.addr_err = bad_F;

        // a clear still lets the PC advance, but only real commits are counted
        pc_d        = stall ? pc_q : npc;
        fetch_cnt_d = (stall || clr_D) ? fetch_cnt_q : fetch_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= PC_RESET;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_D),
        .en    (!stall),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign pc_F       = pc_q;
    assign add4_F     = pc_q + 32'd4;
    assign imem_addr  = pc_q[11:2];
    assign fetch_cnt  = fetch_cnt_q;
    assign instr_D    = if_id_q.instr;
    assign pc_D       = if_id_q.pc;
    assign pc4_D      = if_id_q.pc4;
    assign valid_D    = if_id_q.valid;
    assign addr_err_D = if_id_q.addr_err;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step drives inputs, takes one rising edge,
// and compares every output against hand-computed values.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        clr_D;
    logic [31:0] imem_rdata;
    logic [9:0]  imem_addr;
    logic [31:0] pc_F, add4_F, instr_D, pc_D, pc4_D, fetch_cnt;
    logic        valid_D, addr_err_D;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .clr_D      (clr_D),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .pc_F       (pc_F),
        .add4_F     (add4_F),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .pc4_D      (pc4_D),
        .valid_D    (valid_D),
        .addr_err_D (addr_err_D),
        .fetch_cnt  (fetch_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // drive inputs, then sample 1 time unit after the rising edge
    task automatic applyStimulus(input logic rst, input logic [31:0] n, input logic stl,
                                 input logic clr, input logic [31:0] rdata);
        reset      = rst;
        npc        = n;
        stall      = stl;
        clr_D      = clr;
        imem_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pcd, input logic [31:0] e_pc4,
                            input logic e_valid, input logic e_err, input logic [31:0] e_cnt);
        checkOutput({tag, ".pc_F"},       pc_F, e_pc);
        checkOutput({tag, ".add4_F"},     add4_F, e_pc + 32'd4);
        checkOutput({tag, ".imem_addr"},  32'(imem_addr), 32'(e_pc[11:2]));
        checkOutput({tag, ".instr_D"},    instr_D, e_instr);
        checkOutput({tag, ".pc_D"},       pc_D, e_pcd);
        checkOutput({tag, ".pc4_D"},      pc4_D, e_pc4);
        checkOutput({tag, ".valid_D"},    32'(valid_D), 32'(e_valid));
        checkOutput({tag, ".addr_err_D"}, 32'(addr_err_D), 32'(e_err));
        checkOutput({tag, ".fetch_cnt"},  fetch_cnt, e_cnt);
    endtask

    initial begin
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h2408_0001);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h2408_0001);
        checkAll("reset", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        applyStimulus(1'b0, 32'h3004, 1'b0, 1'b0, 32'h2408_0001);
        checkAll("first", 32'h3004, 32'h2408_0001, 32'h3000, 32'h3004, 1'b1, 1'b0, 32'd1);

        applyStimulus(1'b0, 32'h3008, 1'b0, 1'b0, 32'h1111_1111);
        checkAll("second", 32'h3008, 32'h1111_1111, 32'h3004, 32'h3008, 1'b1, 1'b0, 32'd2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h300C, 1'b1, 1'b0, 32'h2222_2222);
            checkAll("stall", 32'h3008, 32'h1111_1111, 32'h3004, 32'h3008, 1'b1, 1'b0, 32'd2);
        end

        applyStimulus(1'b0, 32'h300C, 1'b0, 1'b0, 32'h2222_2222);
        checkAll("release", 32'h300C, 32'h2222_2222, 32'h3008, 32'h300C, 1'b1, 1'b0, 32'd3);

        applyStimulus(1'b0, 32'h3100, 1'b0, 1'b0, 32'h3333_3333);
        checkAll("jump", 32'h3100, 32'h3333_3333, 32'h300C, 32'h3010, 1'b1, 1'b0, 32'd4);
        checkOutput("jump.imem_addr_lit", 32'(imem_addr), 32'h040);

        applyStimulus(1'b0, 32'h3104, 1'b0, 1'b0, 32'h4444_4444);
        checkAll("jump_commit", 32'h3104, 32'h4444_4444, 32'h3100, 32'h3104, 1'b1, 1'b0, 32'd5);

        applyStimulus(1'b0, 32'h3002, 1'b0, 1'b0, 32'h5555_5555);
        checkAll("to_misaligned", 32'h3002, 32'h5555_5555, 32'h3104, 32'h3108, 1'b1, 1'b0, 32'd6);

        applyStimulus(1'b0, 32'h4000, 1'b0, 1'b0, 32'h6666_6666);
        checkAll("misaligned", 32'h4000, 32'h0, 32'h3002, 32'h3006, 1'b1, 1'b1, 32'd7);

        applyStimulus(1'b0, 32'h3010, 1'b0, 1'b0, 32'h7777_7777);
        checkAll("out_of_range", 32'h3010, 32'h0, 32'h4000, 32'h4004, 1'b1, 1'b1, 32'd8);

        applyStimulus(1'b0, 32'h3020, 1'b1, 1'b1, 32'h7777_7777);
        checkAll("clr_stall", 32'h3010, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd8);

        applyStimulus(1'b0, 32'h3FFC, 1'b0, 1'b0, 32'h8888_8888);
        checkAll("to_last", 32'h3FFC, 32'h8888_8888, 32'h3010, 32'h3014, 1'b1, 1'b0, 32'd9);

        applyStimulus(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h9999_9999);
        checkAll("last_word", 32'hFFFF_FFFC, 32'h9999_9999, 32'h3FFC, 32'h4000, 1'b1, 1'b0, 32'd10);
        checkOutput("wrap.add4_F", add4_F, 32'h0);

        applyStimulus(1'b0, 32'h3000, 1'b0, 1'b0, 32'hAAAA_AAAA);
        checkAll("wrap", 32'h3000, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 32'd11);

        applyStimulus(1'b0, 32'h3004, 1'b0, 1'b1, 32'hBBBB_BBBB);
        checkAll("clr_only", 32'h3004, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd11);

        applyStimulus(1'b0, 32'h3008, 1'b0, 1'b0, 32'hCCCC_CCCC);
        checkAll("after_clr", 32'h3008, 32'hCCCC_CCCC, 32'h3004, 32'h3008, 1'b1, 1'b0, 32'd12);

        applyStimulus(1'b1, 32'h3100, 1'b1, 1'b1, 32'hDDDD_DDDD);
        checkAll("reset_prio", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
